led_shift_out: RTL and testbench

Downstream output stage for the bound flasher. It takes the flasher's 16-bit `LED` word and serialises it MSB-first into a chain of two 8-bit serial-in/parallel-out shift registers with output latch (74HC595-style). A new frame is sent whenever the word differs from the last one delivered. The block presents a clock/data/latch triple to the board pins.

---
 rtl/led_shift_out_pkg.sv | 16 +
 rtl/led_shift_out_clk_div_tick.sv | 38 +++
 rtl/led_shift_out.sv | 132 +++++++++++++
 tb/tb_led_shift_out.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_shift_out_pkg.sv
// Shared types and constants for the LED serial output stage.
// State encoding follows the flasher's 2-bit state style.
package led_shift_out_pkg;

    localparam int LED_W           = 16;
    localparam int IDX_W           = 4;
    localparam int DIV_W           = 8;
    localparam int CLK_DIV_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_LATCH = 2'b10
    } state_e;

endpackage

// File: rtl/led_shift_out_clk_div_tick.sv
// Half-period strobe generator: a down-counter that reloads at terminal count.
// Held at its reload value while clr_i is high so every frame starts phase-aligned.
module led_shift_out_clk_div_tick
    import led_shift_out_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [DIV_W-1:0] RELOAD = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tick_o = ~clr_i & (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || (cnt_q == '0)) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_shift_out.sv
// Serialises the 16-bit LED word MSB-first into a pair of 74HC595-style registers.
// state    | meaning
// ST_IDLE  | waiting for led_in != last_sent or a pending refresh
// ST_SHIFT | clocking 16 bits out, sdata moves on the falling sclk edge
// ST_LATCH | latch high for one half-period, then frame_done
module led_shift_out
    import led_shift_out_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LED_W-1:0] led_in,
    output logic             sclk,
    output logic             sdata,
    output logic             latch,
    output logic             busy,
    output logic             frame_done
);

    state_e             state_q, state_d;
    logic [LED_W-1:0]   shadow_q, shadow_d;
    logic [LED_W-1:0]   last_sent_q, last_sent_d;
    logic               refresh_q, refresh_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic               phase_q, phase_d;
    logic               sdata_q, sdata_d;
    logic               latch_q, latch_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               tick;

    led_shift_out_clk_div_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div_tick (
        .clk    (clk),
        .rst_n  (reset),
        .clr_i  (state_q == ST_IDLE),
        .tick_o (tick)
    );

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        last_sent_d  = last_sent_q;
        refresh_d    = refresh_q;
        bit_idx_d    = bit_idx_q;
        phase_d      = phase_q;
        sdata_d      = sdata_q;
        latch_d      = latch_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if ((led_in != last_sent_q) || refresh_q) begin
                    shadow_d  = led_in;
                    sdata_d   = led_in[LED_W-1];
                    bit_idx_d = IDX_W'(LED_W - 1);
                    phase_d   = 1'b0;
                    busy_d    = 1'b1;
                    refresh_d = 1'b0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        // Falling sclk edge: the only place the data line may move.
                        phase_d = 1'b0;
                        if (bit_idx_q == '0) begin
                            latch_d = 1'b1;
                            state_d = ST_LATCH;
                        end else begin
                            bit_idx_d = bit_idx_q - IDX_W'(1);
                            sdata_d   = shadow_q[bit_idx_d];
                        end
                    end
                end
            end
            ST_LATCH: begin
                if (tick) begin
                    latch_d      = 1'b0;
                    sdata_d      = 1'b0;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                    last_sent_d  = shadow_q;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            shadow_q     <= '0;
            last_sent_q  <= '0;
            refresh_q    <= 1'b1;
            bit_idx_q    <= '0;
            phase_q      <= 1'b0;
            sdata_q      <= 1'b0;
            latch_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            last_sent_q  <= last_sent_d;
            refresh_q    <= refresh_d;
            bit_idx_q    <= bit_idx_d;
            phase_q      <= phase_d;
            sdata_q      <= sdata_d;
            latch_q      <= latch_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // phase_q is forced low outside SHIFT, so it doubles as the registered sclk.
    assign sclk       = phase_q;
    assign sdata      = sdata_q;
    assign latch      = latch_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_shift_out.sv
// Bench for led_shift_out: a CLK_DIV=2 instance checked against a frame-level
// model and bit monitor, plus a CLK_DIV=1 instance for the fast-clock case.
module tb_led_shift_out;

    localparam int DA = 2;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] led_a = 16'h0000;
    logic [15:0] led_b = 16'h0000;
    logic        sclk_a, sdata_a, latch_a, busy_a, done_a;
    logic        sclk_b, sdata_b, latch_b, busy_b, done_b;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    led_shift_out #(.CLK_DIV(DA)) dut (
        .clk        (clk),
        .reset      (reset),
        .led_in     (led_a),
        .sclk       (sclk_a),
        .sdata      (sdata_a),
        .latch      (latch_a),
        .busy       (busy_a),
        .frame_done (done_a)
    );

    led_shift_out #(.CLK_DIV(1)) dut_fast (
        .clk        (clk),
        .reset      (reset),
        .led_in     (led_b),
        .sclk       (sclk_b),
        .sdata      (sdata_b),
        .latch      (latch_b),
        .busy       (busy_b),
        .frame_done (done_b)
    );

    // Frame-level reference: a frame is a busy window of 33*CLK_DIV cycles that
    // starts whenever the model is idle and the word differs or a refresh is owed.
    int          m_left    = 0;
    logic [15:0] m_last    = 16'h0000;
    logic [15:0] m_word    = 16'h0000;
    bit          m_refresh = 1'b1;
    bit          m_done    = 1'b0;
    logic [15:0] exp_q[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            if (m_left > 0 && exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
            m_left    = 0;
            m_refresh = 1'b1;
            m_last    = 16'h0000;
            m_done    = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_last = m_word;
                    m_done = 1'b1;
                end
            end else if ((led_a != m_last) || m_refresh) begin
                m_word    = led_a;
                m_refresh = 1'b0;
                m_left    = 33 * DA;
                exp_q.push_back(led_a);
            end
        end
    end

    // Pin monitor: reassembles words from rising sclk, tallies protocol breaches.
    logic [15:0] got_q[$];
    logic [15:0] sh = 16'h0000;
    int   nbits = 0, proto_err = 0, done_cnt = 0, cyc = 0;
    int   latch_run = 0, latch_len_last = 0, busy_run = 0, busy_len_last = 0;
    int   done_cyc = 0, rise_cyc = 0;
    logic p_sclk = 1'b0, p_sdata = 1'b0, p_latch = 1'b0, p_busy = 1'b0;

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            nbits     = 0;
            latch_run = 0;
            busy_run  = 0;
            p_sclk    = 1'b0;
            p_sdata   = 1'b0;
            p_latch   = 1'b0;
            p_busy    = 1'b0;
        end else begin
            cyc++;
            if (busy_a !== (m_left > 0)) proto_err++;
            if (done_a !== m_done) proto_err++;
            if (sclk_a && (!busy_a || latch_a)) proto_err++;
            if (!busy_a && (sdata_a || latch_a)) proto_err++;
            if (busy_a && p_busy && (sdata_a !== p_sdata) && !(p_sclk && !sclk_a)) proto_err++;
            if (sclk_a && !p_sclk) begin
                sh = {sh[14:0], sdata_a};
                nbits++;
            end
            if (latch_a) latch_run++;
            if (latch_a && !p_latch) begin
                got_q.push_back(sh);
                if (nbits != 16) proto_err++;
                nbits = 0;
            end
            if (!latch_a && p_latch) begin
                latch_len_last = latch_run;
                latch_run      = 0;
            end
            if (busy_a) busy_run++;
            if (busy_a && !p_busy) rise_cyc = cyc;
            if (!busy_a && p_busy) begin
                busy_len_last = busy_run;
                busy_run      = 0;
            end
            if (done_a) begin
                done_cnt++;
                done_cyc = cyc;
            end
            p_sclk  = sclk_a;
            p_sdata = sdata_a;
            p_latch = latch_a;
            p_busy  = busy_a;
        end
    end

    task automatic wait_done(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        reset = 1'b0;
        led_a = 16'h0000;
        led_b = 16'h0000;
        repeat (3) @(negedge clk);
        vectors++;
        if ({sclk_a, sdata_a, latch_a, busy_a, done_a} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outputs: got %b, want 00000", {sclk_a, sdata_a, latch_a, busy_a, done_a});
        end
        got_q.delete();
        reset = 1'b1;
        wait_done(1, 300, ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_frame_timeout: done_cnt %0d, want 1", done_cnt);
        end
        vectors++;
        if (got_q.size() != 1 || got_q[0] !== 16'h0000) begin
            errors++;
            $display("FAIL reset_frame_word: got %0d words first %h, want 1 word 0000", got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'hxxxx);
        end
        vectors++;
        if (busy_len_last != 33 * DA) begin
            errors++;
            $display("FAIL reset_busy_len: got %0d, want %0d", busy_len_last, 33 * DA);
        end
        vectors++;
        if (latch_len_last != DA) begin
            errors++;
            $display("FAIL reset_latch_len: got %0d, want %0d", latch_len_last, DA);
        end
        repeat (200) @(negedge clk);
        vectors++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL reset_no_extra_frame: done_cnt %0d, want 1", done_cnt);
        end
        vectors++;
        if (proto_err != 0) begin
            errors++;
            $display("FAIL reset_protocol: %0d breaches, want 0", proto_err);
        end
    endtask

    task automatic test_single();
        bit ok;
        int d0 = done_cnt;
        got_q.delete();
        led_a = 16'h003F;
        wait_done(d0 + 1, 300, ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL single_timeout: done_cnt %0d, want %0d", done_cnt, d0 + 1);
        end
        vectors++;
        if (got_q.size() != 1 || got_q[0] !== 16'h003F) begin
            errors++;
            $display("FAIL single_word: got %0d words first %h, want 1 word 003f", got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'hxxxx);
        end
        vectors++;
        if (dut.last_sent_q !== 16'h003F) begin
            errors++;
            $display("FAIL single_last_sent: got %h, want 003f", dut.last_sent_q);
        end
        repeat (200) @(negedge clk);
        vectors++;
        if (done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL single_hold: done_cnt %0d, want %0d", done_cnt, d0 + 1);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int d0 = done_cnt;
        int first_done;
        got_q.delete();
        led_a = 16'h0001;
        repeat (20) @(negedge clk);
        led_a = 16'h0003;
        repeat (20) @(negedge clk);
        led_a = 16'h0007;
        wait_done(d0 + 1, 300, ok);
        first_done = done_cyc;
        wait_done(d0 + 2, 300, ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_timeout: done_cnt %0d, want %0d", done_cnt, d0 + 2);
        end
        vectors++;
        if (got_q.size() != 2 || got_q[0] !== 16'h0001 || got_q[1] !== 16'h0007) begin
            errors++;
            $display("FAIL b2b_words: got %0d words, want 0001 then 0007", got_q.size());
        end
        vectors++;
        if (rise_cyc != first_done + 1) begin
            errors++;
            $display("FAIL b2b_restart: busy rose at %0d, want %0d", rise_cyc, first_done + 1);
        end
        repeat (200) @(negedge clk);
        vectors++;
        if (done_cnt != d0 + 2) begin
            errors++;
            $display("FAIL b2b_frame_count: done_cnt %0d, want %0d", done_cnt, d0 + 2);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit reached = 1'b0;
        int d0;
        got_q.delete();
        led_a = 16'hFFFF;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (nbits == 8) begin
                reached = 1'b1;
                break;
            end
        end
        vectors++;
        if (!reached) begin
            errors++;
            $display("FAIL midreset_reach_bit7: bits %0d, want 8", nbits);
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({sclk_a, sdata_a, latch_a, busy_a} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_outputs: got %b, want 0000", {sclk_a, sdata_a, latch_a, busy_a});
        end
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        reset = 1'b1;
        wait_done(d0 + 1, 300, ok);
        vectors++;
        if (!ok || got_q.size() != 1 || got_q[0] !== 16'hFFFF) begin
            errors++;
            $display("FAIL midreset_refresh: got %0d words first %h, want 1 word ffff", got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'hxxxx);
        end
    endtask

    task automatic test_clkdiv1();
        logic [15:0] w = 16'h0000;
        int   nb = 0, blen = 0, bad = 0, dn = 0;
        bit   seen = 1'b0;
        logic pc = 1'b0, ps = 1'b0, pb = 1'b0, pl = 1'b0;
        for (int i = 0; i < 100 && busy_b; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        led_b = 16'hA5A5;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_b) dn++;
            if (busy_b) begin
                seen = 1'b1;
                blen++;
                if (pb && !pl && !latch_b && (sclk_b === pc)) bad++;
                if (sclk_b && !pc) begin
                    w = {w[14:0], sdata_b};
                    nb++;
                    if (sdata_b !== ps) bad++;
                end
                if (latch_b && sclk_b) bad++;
            end else if (seen) begin
                break;
            end
            pc = sclk_b;
            ps = sdata_b;
            pb = busy_b;
            pl = latch_b;
        end
        vectors++;
        if (blen != 33) begin
            errors++;
            $display("FAIL div1_busy_len: got %0d, want 33", blen);
        end
        vectors++;
        if (w !== 16'hA5A5 || nb != 16) begin
            errors++;
            $display("FAIL div1_word: got %h over %0d edges, want a5a5 over 16", w, nb);
        end
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL div1_sclk_sdata: %0d breaches, want 0", bad);
        end
        vectors++;
        if (dn != 1) begin
            errors++;
            $display("FAIL div1_frame_done: got %0d pulses, want 1", dn);
        end
    endtask

    task automatic test_random();
        int d0;
        int shown = 0;
        bit hit = 1'b0;
        repeat (200) @(negedge clk);
        got_q.delete();
        exp_q.delete();
        d0 = done_cnt;
        for (int i = 0; i < 60000; i++) begin
            @(negedge clk);
            if ($urandom_range(19) == 0) led_a = 16'($urandom);
            if (done_cnt >= d0 + 200) begin
                hit = 1'b1;
                break;
            end
        end
        repeat (200) @(negedge clk);
        vectors++;
        if (!hit) begin
            errors++;
            $display("FAIL rand_frames: got %0d frames, want 200", done_cnt - d0);
        end
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d words, want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                if (shown < 10) $display("FAIL rand_word[%0d]: got %h, want %h", i, got_q[i], exp_q[i]);
                shown++;
            end
        end
        vectors++;
        if (got_q.size() == 0 || got_q[got_q.size() - 1] !== led_a) begin
            errors++;
            $display("FAIL rand_final: got %h, want %h", (got_q.size() > 0) ? got_q[got_q.size() - 1] : 16'hxxxx, led_a);
        end
        vectors++;
        if (proto_err != 0) begin
            errors++;
            $display("FAIL protocol_total: %0d breaches, want 0", proto_err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
        test_clkdiv1();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
